cpu_control_unit: RTL
=====================

CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15: RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: word width of RAM, registers and ALU.
REQ-003 SHALL have parameter RESET_PC, default 16'h0100: PC value after reset.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: in IDLE, begin execution at current PC.
REQ-007 SHALL have port mem_addr, output, ADDR_WIDTH bits: RAM address (MAR).
REQ-008 SHALL have port mem_rdata, input, DATA_WIDTH bits: RAM read data, valid 1 cycle after a read is presented.
REQ-009 SHALL have port mem_wdata, output, DATA_WIDTH bits: RAM write data (MBR).
REQ-010 SHALL have ports mem_cs, mem_we, mem_oe, output, 1 bit each: RAM chip select, write enable, output enable.
REQ-011 SHALL have ports alu_a, alu_b, output, DATA_WIDTH bits each: ALU operands (AC, MBR).
REQ-012 SHALL have port alu_sel, output, 4 bits: ALU select; 1 add, 2 sub, 3 and, 4 or, 5 not.
REQ-013 SHALL have port alu_out, input, DATA_WIDTH bits: combinational ALU result.
REQ-014 SHALL have ports pc and ac, output, 16 bits and DATA_WIDTH bits: architectural PC and accumulator.
REQ-015 SHALL have port instr_done, output, 1 bit: one-cycle pulse on the last cycle of each instruction.
REQ-016 SHALL have port halted, output, 1 bit: high while in HALT.

Function
REQ-017 States SHALL be IDLE, F_ADDR, F_LATCH, DECODE, OP_ADDR, OP_READ, EXEC, ST_WRITE and HALT.
REQ-018 IDLE SHALL hold all registers; start=1 SHALL go to F_ADDR next cycle.
REQ-019 F_ADDR SHALL drive mem_addr=PC[ADDR_WIDTH-1:0], cs=1, oe=1, we=0; next state F_LATCH.
REQ-020 F_LATCH SHALL load IR<=mem_rdata; next state DECODE.
REQ-021 DECODE SHALL load PC<=PC+1 (16-bit wrap) and branch on IR[15:12].
REQ-022 DECODE SHALL send opcodes 1, 3, 4, 5, 6 and F to OP_ADDR, opcode 2 to OP_ADDR, opcodes 8, 9, A and B to EXEC, and opcode E to HALT.
REQ-023 Any other opcode SHALL be a no-op: pulse instr_done and return to F_ADDR.
REQ-024 OP_ADDR SHALL drive mem_addr={0,IR[11:0]}, cs=1; for reads oe=1, we=0, next OP_READ.
REQ-025 For Store (2), OP_ADDR SHALL also load MBR<=AC; next ST_WRITE.
REQ-026 OP_READ SHALL load MBR<=mem_rdata; next EXEC.
REQ-027 ST_WRITE SHALL drive cs=1, we=1, oe=0, mem_wdata=MBR, mem_addr held for exactly one cycle; then F_ADDR.
REQ-028 EXEC for Load (1) SHALL set AC<=MBR.
REQ-029 EXEC for opcodes 3/4/5/6/F SHALL drive alu_a=AC, alu_b=MBR, alu_sel=1/2/3/4/5 and set AC<=alu_out.
REQ-030 Arithmetic SHALL be DATA_WIDTH modular with no flags.
REQ-031 EXEC for Back (8) SHALL set PC<=PC-1; for Jump (A) PC<=IR[11:0] zero-extended; for Clear (B) AC<=0.
REQ-032 EXEC for Skip (9) SHALL set PC<=PC+1 when IR[11:10]=00 and AC is negative (signed, AC[15]=1).
REQ-033 EXEC for Skip SHALL set PC<=PC+1 when IR[11:10]=01 and AC==0, or IR[11:10]=10 and AC is signed >0.
REQ-034 Skip with IR[11:10]=11 SHALL never skip.
REQ-035 instr_done SHALL pulse in EXEC, ST_WRITE, HALT-entry and no-op DECODE cycles; the next state is F_ADDR except after HALT.
REQ-036 Latency from F_ADDR SHALL be: load/ALU 6 cycles, store 5, PC/AC control 4, no-op 3.
REQ-037 HALT SHALL hold halted=1 and cs=we=oe=0, ignore start, and exit only by rst.
REQ-038 In states without memory access, mem_cs, mem_we and mem_oe SHALL be 0; alu_sel SHALL be 0 outside ALU EXEC.

Reset
REQ-039 rst=1 SHALL immediately force state IDLE, PC=RESET_PC, IR=MBR=AC=0, mem_cs=mem_we=mem_oe=0, instr_done=0 and halted=0, in any state including mid-ST_WRITE.

Verification
REQ-040 A bench SHALL run mem[100..103]=1110,3111,2112,E000 with mem[110]=5 and mem[111]=7, pulse start, and require mem[112]=000C, ac=000C, pc=0104 and halted=1.
REQ-041 A bench SHALL preload AC=3 via Load, then run Sub of 5 and Skip 9000, and require ac=FFFE with the instruction after the skip not executed (pc advances by 2).
REQ-042 A bench SHALL run Jump A120 and require the next F_ADDR mem_addr=0120, with 4 cycles from F_ADDR to instr_done.
REQ-043 A bench SHALL run Add 0001 with AC=FFFF and require ac=0000 (wrap) and instr_done exactly 6 cycles after F_ADDR.
REQ-044 A bench SHALL assert rst during ST_WRITE and require mem_we to fall before the next edge, the target word unchanged, and pc=0100 in IDLE.
REQ-045 A bench SHALL run opcode 7123 and require a 3-cycle no-op with ac unchanged and pc incremented by 1.

Source files
------------

// File: rtl/cpu_control_unit.sv
// Multi-cycle accumulator CPU sequencer: fetch/decode/operand/execute FSM driving RAM and an external ALU.
// Latency from fetch: load/ALU 6, store 5, PC/AC control 4, no-op/halt 3 cycles; no backpressure, RAM is fixed 1-cycle.
module cpu_control_unit #(
    parameter int          ADDR_WIDTH = 15,
    parameter int          DATA_WIDTH = 16,
    parameter logic [15:0] RESET_PC   = 16'h0100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [3:0]            alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic [15:0]           pc,
    output logic [DATA_WIDTH-1:0] ac,
    output logic                  instr_done,
    output logic                  halted
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_F_ADDR,
        S_F_LATCH,
        S_DECODE,
        S_OP_ADDR,
        S_OP_READ,
        S_EXEC,
        S_ST_WRITE,
        S_HALT
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           pc_q, pc_d;
    logic [15:0]           ir_q, ir_d;
    logic [DATA_WIDTH-1:0] mbr_q, mbr_d;
    logic [DATA_WIDTH-1:0] ac_q, ac_d;

    logic [3:0]            opcode;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  ac_neg;
    logic                  ac_zero;
    logic                  skip_take;
    logic [3:0]            exec_alu_sel;

    assign opcode     = ir_q[15:12];
    assign op_addr    = ADDR_WIDTH'(ir_q[11:0]);
    assign fetch_addr = ADDR_WIDTH'(pc_q);
    assign ac_neg     = ac_q[DATA_WIDTH-1];
    assign ac_zero    = (ac_q == '0);

    assign mem_wdata = mbr_q;
    assign alu_a     = ac_q;
    assign alu_b     = mbr_q;
    assign pc        = pc_q;
    assign ac        = ac_q;

    // Skip condition field IR[11:10]: negative, zero, strictly positive, never.
    always_comb begin
        skip_take = 1'b0;
        unique case (ir_q[11:10])
            2'b00:   skip_take = ac_neg;
            2'b01:   skip_take = ac_zero;
            2'b10:   skip_take = !ac_neg && !ac_zero;
            default: skip_take = 1'b0;
        endcase
    end

    always_comb begin
        exec_alu_sel = 4'd0;
        case (opcode)
            4'h3:    exec_alu_sel = 4'd1;
            4'h4:    exec_alu_sel = 4'd2;
            4'h5:    exec_alu_sel = 4'd3;
            4'h6:    exec_alu_sel = 4'd4;
            4'hF:    exec_alu_sel = 4'd5;
            default: exec_alu_sel = 4'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        mbr_d      = mbr_q;
        ac_d       = ac_q;
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        mem_oe     = 1'b0;
        mem_addr   = '0;
        alu_sel    = 4'd0;
        instr_done = 1'b0;
        halted     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_F_ADDR;
            end
            S_F_ADDR: begin
                mem_addr = fetch_addr;
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
                state_d  = S_F_LATCH;
            end
            S_F_LATCH: begin
                ir_d    = mem_rdata[15:0];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                pc_d = pc_q + 16'd1;
                case (opcode)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF: state_d = S_OP_ADDR;
                    4'h8, 4'h9, 4'hA, 4'hB:                   state_d = S_EXEC;
                    4'hE: begin
                        instr_done = 1'b1;
                        state_d    = S_HALT;
                    end
                    default: begin
                        instr_done = 1'b1;
                        state_d    = S_F_ADDR;
                    end
                endcase
            end
            S_OP_ADDR: begin
                mem_addr = op_addr;
                mem_cs   = 1'b1;
                if (opcode == 4'h2) begin
                    // Store: capture AC now so ST_WRITE can present it as write data.
                    mbr_d   = ac_q;
                    state_d = S_ST_WRITE;
                end else begin
                    mem_oe  = 1'b1;
                    state_d = S_OP_READ;
                end
            end
            S_OP_READ: begin
                mbr_d   = mem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                instr_done = 1'b1;
                state_d    = S_F_ADDR;
                case (opcode)
                    4'h1: ac_d = mbr_q;
                    4'h3, 4'h4, 4'h5, 4'h6, 4'hF: begin
                        alu_sel = exec_alu_sel;
                        ac_d    = alu_out;
                    end
                    4'h8: pc_d = pc_q - 16'd1;
                    4'h9: if (skip_take) pc_d = pc_q + 16'd1;
                    4'hA: pc_d = {4'h0, ir_q[11:0]};
                    4'hB: ac_d = '0;
                    default: ;
                endcase
            end
            S_ST_WRITE: begin
                mem_addr   = op_addr;
                mem_cs     = 1'b1;
                mem_we     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_F_ADDR;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from state, so async reset drops them without waiting for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            mbr_q   <= '0;
            ac_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mbr_q   <= mbr_d;
            ac_q    <= ac_d;
        end
    end

endmodule
